// File: rtl/dm_pkg.sv
// Shared definitions for the debug-module system bus side.
// Holds the AXI response codes, the default AxPROT value used by the
// SBA-to-AXI-Lite bridge, and a helper that classifies a response as an error.
package dm_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    // Unprivileged, non-secure, data access.
    localparam logic [2:0] AXI_PROT_DEFAULT = 3'b010;

    // SLVERR and DECERR both report as a bus error upstream.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == AXI_RESP_SLVERR) || (resp == AXI_RESP_DECERR);
    endfunction

endpackage

// File: rtl/dm_sba_axil_bridge.sv
// Bridges the debug-module system bus access port (req/gnt/r_valid, one
// transaction outstanding) onto an AXI4-Lite master.
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   dmactive_i           debug module active; low blocks grants and
//                        suppresses the completion pulse
//   req_i..be_i, gnt_o   upstream request and grant
//   r_valid_o, r_rdata_o, err_o  registered one-cycle completion
//   aw_*, w_*, b_*, ar_*, r_*    AXI4-Lite master channels
module dm_sba_axil_bridge
    import dm_pkg::*;
#(
    parameter int unsigned BusWidth = 32,
    parameter logic [2:0]  AxProt   = AXI_PROT_DEFAULT
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  dmactive_i,
    input  logic                  req_i,
    input  logic [BusWidth-1:0]   add_i,
    input  logic                  we_i,
    input  logic [BusWidth-1:0]   wdata_i,
    input  logic [BusWidth/8-1:0] be_i,
    output logic                  gnt_o,
    output logic                  r_valid_o,
    output logic [BusWidth-1:0]   r_rdata_o,
    output logic                  err_o,
    output logic                  aw_valid_o,
    input  logic                  aw_ready_i,
    output logic [BusWidth-1:0]   aw_addr_o,
    output logic [2:0]            aw_prot_o,
    output logic                  w_valid_o,
    input  logic                  w_ready_i,
    output logic [BusWidth-1:0]   w_data_o,
    output logic [BusWidth/8-1:0] w_strb_o,
    input  logic                  b_valid_i,
    output logic                  b_ready_o,
    input  logic [1:0]            b_resp_i,
    output logic                  ar_valid_o,
    input  logic                  ar_ready_i,
    output logic [BusWidth-1:0]   ar_addr_o,
    output logic [2:0]            ar_prot_o,
    input  logic                  r_valid_i,
    output logic                  r_ready_o,
    input  logic [BusWidth-1:0]   r_data_i,
    input  logic [1:0]            r_resp_i
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        WAIT_B,
        WAIT_R
    } state_e;

    state_e                state_q, state_d;
    logic [BusWidth-1:0]   add_q, add_d;
    logic [BusWidth-1:0]   wdata_q, wdata_d;
    logic [BusWidth/8-1:0] be_q, be_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;
    logic                  r_valid_q, r_valid_d;
    logic                  err_q, err_d;
    logic [BusWidth-1:0]   rdata_q, rdata_d;

    always_comb begin
        state_d    = state_q;
        add_d      = add_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        r_valid_d  = 1'b0;
        err_d      = err_q;
        rdata_d    = rdata_q;
        gnt_o      = 1'b0;
        aw_valid_o = 1'b0;
        w_valid_o  = 1'b0;
        b_ready_o  = 1'b0;
        ar_valid_o = 1'b0;
        r_ready_o  = 1'b0;

        unique case (state_q)
            IDLE: begin
                gnt_o = req_i & dmactive_i;
                if (gnt_o) begin
                    add_d   = add_i;
                    wdata_d = wdata_i;
                    be_d    = be_i;
                    state_d = we_i ? WRITE : READ;
                end
            end
            WRITE: begin
                aw_valid_o = ~aw_done_q;
                w_valid_o  = ~w_done_q;
                aw_done_d  = aw_done_q | (aw_valid_o & aw_ready_i);
                w_done_d   = w_done_q | (w_valid_o & w_ready_i);
                // Join the two channels, counting a handshake in this cycle.
                if (aw_done_d && w_done_d) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = WAIT_B;
                end
            end
            READ: begin
                ar_valid_o = 1'b1;
                if (ar_ready_i) begin
                    state_d = WAIT_R;
                end
            end
            WAIT_B: begin
                b_ready_o = 1'b1;
                if (b_valid_i) begin
                    // The fabric transaction always completes; only the
                    // upstream pulse depends on dmactive_i.
                    r_valid_d = dmactive_i;
                    err_d     = resp_is_err(b_resp_i);
                    state_d   = IDLE;
                end
            end
            WAIT_R: begin
                r_ready_o = 1'b1;
                if (r_valid_i) begin
                    r_valid_d = dmactive_i;
                    err_d     = resp_is_err(r_resp_i);
                    rdata_d   = resp_is_err(r_resp_i) ? '0 : r_data_i;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            add_q     <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            r_valid_q <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            add_q     <= add_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            r_valid_q <= r_valid_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
        end
    end

    assign r_valid_o = r_valid_q;
    assign err_o     = err_q;
    assign r_rdata_o = rdata_q;
    assign aw_addr_o = add_q;
    assign ar_addr_o = add_q;
    assign w_data_o  = wdata_q;
    assign w_strb_o  = be_q;
    assign aw_prot_o = AxProt;
    assign ar_prot_o = AxProt;

endmodule

// File: tb/tb_dm_sba_axil_bridge.sv
module tb_dm_sba_axil_bridge;

    localparam int NUM_RAND = 150;
    localparam int NUM_DIR  = 7;
    localparam int TOTAL    = NUM_DIR + NUM_RAND;
    localparam int MAXT     = 256;
    localparam int BUDGET   = 20000;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        dmactive_i = 1'b0;
    logic        req_i = 1'b0;
    logic [31:0] add_i = '0;
    logic        we_i = 1'b0;
    logic [31:0] wdata_i = '0;
    logic [3:0]  be_i = '0;
    logic        gnt_o, r_valid_o, err_o;
    logic [31:0] r_rdata_o;
    logic        aw_valid_o, aw_ready_i = 1'b0;
    logic [31:0] aw_addr_o;
    logic [2:0]  aw_prot_o;
    logic        w_valid_o, w_ready_i = 1'b0;
    logic [31:0] w_data_o;
    logic [3:0]  w_strb_o;
    logic        b_valid_i = 1'b0, b_ready_o;
    logic [1:0]  b_resp_i = '0;
    logic        ar_valid_o, ar_ready_i = 1'b0;
    logic [31:0] ar_addr_o;
    logic [2:0]  ar_prot_o;
    logic        r_valid_i = 1'b0, r_ready_o;
    logic [31:0] r_data_i = '0;
    logic [1:0]  r_resp_i = '0;

    dm_sba_axil_bridge #(.BusWidth(32), .AxProt(3'b010)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .dmactive_i(dmactive_i),
        .req_i(req_i), .add_i(add_i), .we_i(we_i), .wdata_i(wdata_i), .be_i(be_i),
        .gnt_o(gnt_o), .r_valid_o(r_valid_o), .r_rdata_o(r_rdata_o), .err_o(err_o),
        .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i), .aw_addr_o(aw_addr_o), .aw_prot_o(aw_prot_o),
        .w_valid_o(w_valid_o), .w_ready_i(w_ready_i), .w_data_o(w_data_o), .w_strb_o(w_strb_o),
        .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_resp_i(b_resp_i),
        .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i), .ar_addr_o(ar_addr_o), .ar_prot_o(ar_prot_o),
        .r_valid_i(r_valid_i), .r_ready_o(r_ready_o), .r_data_i(r_data_i), .r_resp_i(r_resp_i)
    );

    always #5 clk_i = ~clk_i;

    // One upstream request plus how the simulated slave answers it.
    typedef struct {
        bit          we;
        bit [31:0]   addr;
        bit [31:0]   data;
        bit [3:0]    be;
        bit [31:0]   rdata;
        bit [1:0]    resp;
        int unsigned aw_dly, w_dly, ar_dly, rsp_dly;
        bit          drop;
    } txn_t;

    txn_t q[$];
    txn_t cur;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Transaction-level model state.
    bit busy, aw_seen, w_seen, ar_seen, req_active, rand_mode, drop_started;
    int unsigned aw_wait, w_wait, ar_wait, rsp_wait;
    int drop_left, gen_cnt, done_cnt, next_id, cur_id, last_done;
    bit pulse_now, e_err;
    bit [31:0] e_rdata;
    bit e_gnt, e_aw, e_w, e_ar, e_b, e_r;

    // Per-transaction observations of the DUT.
    int grant_c[MAXT], pulse_c[MAXT], pulse_n[MAXT], aw_n[MAXT], w_n[MAXT];
    int aw_c[MAXT], w_c[MAXT], ar_c[MAXT];
    bit pulse_err[MAXT];
    bit [31:0] pulse_rd[MAXT], ar_addr_log[MAXT];
    bit [3:0]  w_strb_log[MAXT];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic txn_t mk(input bit we, input bit [31:0] addr, input bit [31:0] data,
                                input bit [3:0] be, input bit [31:0] rdata, input bit [1:0] resp,
                                input int unsigned awd, input int unsigned wd,
                                input int unsigned ard, input int unsigned rd, input bit drop);
        txn_t t;
        t.we = we; t.addr = addr; t.data = data; t.be = be; t.rdata = rdata; t.resp = resp;
        t.aw_dly = awd; t.w_dly = wd; t.ar_dly = ard; t.rsp_dly = rd; t.drop = drop;
        return t;
    endfunction

    task automatic cycle_step();
        txn_t nt;
        bit aw_hs, w_hs, ar_hs, rsp_hs, nxt_pulse;
        @(posedge clk_i);
        #1;
        cyc++;
        if (rand_mode && q.size() == 0 && gen_cnt < NUM_RAND) begin
            q.push_back(mk(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)),
                           $urandom, 2'($urandom_range(0, 3)), $urandom_range(0, 3),
                           $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                           $urandom_range(0, 9) == 0));
            gen_cnt++;
        end
        if (!req_active && q.size() > 0 && (!rand_mode || $urandom_range(0, 3) != 0))
            req_active = 1'b1;
        if (busy && cur.drop && ar_seen && !drop_started) begin
            drop_left = 5;
            drop_started = 1'b1;
        end
        if (rand_mode && !busy && drop_left == 0 && $urandom_range(0, 31) == 0)
            drop_left = $urandom_range(1, 3);
        dmactive_i = (drop_left == 0);
        if (req_active) begin
            nt = q[0];
            req_i = 1'b1; add_i = nt.addr; we_i = nt.we; wdata_i = nt.data; be_i = nt.be;
        end else begin
            req_i = 1'b0; add_i = $urandom; we_i = 1'($urandom_range(0, 1));
            wdata_i = $urandom; be_i = 4'($urandom_range(0, 15));
        end

        e_gnt = req_active && dmactive_i && !busy;
        e_aw  = busy && cur.we && !aw_seen;
        e_w   = busy && cur.we && !w_seen;
        e_ar  = busy && !cur.we && !ar_seen;
        e_b   = busy && cur.we && aw_seen && w_seen;
        e_r   = busy && !cur.we && ar_seen;

        aw_ready_i = e_aw ? (aw_wait >= cur.aw_dly) : (rand_mode && $urandom_range(0, 1) == 1);
        w_ready_i  = e_w  ? (w_wait >= cur.w_dly)   : (rand_mode && $urandom_range(0, 1) == 1);
        ar_ready_i = e_ar ? (ar_wait >= cur.ar_dly) : (rand_mode && $urandom_range(0, 1) == 1);
        b_valid_i  = e_b && rsp_wait >= cur.rsp_dly;
        r_valid_i  = e_r && rsp_wait >= cur.rsp_dly;
        b_resp_i   = b_valid_i ? cur.resp : 2'($urandom_range(0, 3));
        r_resp_i   = r_valid_i ? cur.resp : 2'($urandom_range(0, 3));
        r_data_i   = r_valid_i ? cur.rdata : $urandom;
        #1;

        chk("gnt_o", gnt_o, e_gnt);
        chk("aw_valid_o", aw_valid_o, e_aw);
        chk("w_valid_o", w_valid_o, e_w);
        chk("ar_valid_o", ar_valid_o, e_ar);
        chk("b_ready_o", b_ready_o, e_b);
        chk("r_ready_o", r_ready_o, e_r);
        chk("r_valid_o", r_valid_o, pulse_now);
        chk("aw_prot_o", aw_prot_o, 3'b010);
        chk("ar_prot_o", ar_prot_o, 3'b010);
        if (pulse_now) begin
            chk("err_o", err_o, e_err);
            chk("r_rdata_o", r_rdata_o, e_rdata);
        end
        if (e_aw) chk("aw_addr_o", aw_addr_o, cur.addr);
        if (e_w) begin
            chk("w_data_o", w_data_o, cur.data);
            chk("w_strb_o", w_strb_o, cur.be);
        end
        if (e_ar) chk("ar_addr_o", ar_addr_o, cur.addr);

        if (r_valid_o) begin
            pulse_n[last_done]++;
            pulse_c[last_done] = cyc;
            pulse_err[last_done] = err_o;
            pulse_rd[last_done] = r_rdata_o;
        end
        if (busy && aw_valid_o && aw_ready_i) begin aw_n[cur_id]++; aw_c[cur_id] = cyc; end
        if (busy && w_valid_o && w_ready_i) begin
            w_n[cur_id]++; w_c[cur_id] = cyc; w_strb_log[cur_id] = w_strb_o;
        end
        if (busy && ar_valid_o && ar_ready_i) begin ar_c[cur_id] = cyc; ar_addr_log[cur_id] = ar_addr_o; end

        aw_hs = e_aw && aw_ready_i;
        w_hs  = e_w && w_ready_i;
        ar_hs = e_ar && ar_ready_i;
        rsp_hs = b_valid_i || r_valid_i;
        nxt_pulse = 1'b0;
        if (busy) begin
            if (aw_hs) aw_seen = 1'b1; else if (e_aw) aw_wait++;
            if (w_hs) w_seen = 1'b1; else if (e_w) w_wait++;
            if (ar_hs) ar_seen = 1'b1; else if (e_ar) ar_wait++;
            if (e_b || e_r) begin
                if (rsp_hs) begin
                    busy = 1'b0;
                    done_cnt++;
                    last_done = cur_id;
                    nxt_pulse = dmactive_i;
                    e_err = (cur.resp == 2'b10) || (cur.resp == 2'b11);
                    if (!cur.we) e_rdata = e_err ? 32'h0 : cur.rdata;
                end else begin
                    rsp_wait++;
                end
            end
        end
        if (e_gnt) begin
            cur = q.pop_front();
            cur_id = next_id++;
            busy = 1'b1;
            aw_seen = 0; w_seen = 0; ar_seen = 0;
            aw_wait = 0; w_wait = 0; ar_wait = 0; rsp_wait = 0;
            drop_started = 1'b0;
            req_active = 1'b0;
            grant_c[cur_id] = cyc;
        end
        if (drop_left > 0) drop_left--;
        pulse_now = nxt_pulse;
    endtask

    initial begin
        for (int i = 0; i < MAXT; i++) begin
            grant_c[i] = -1; pulse_c[i] = -1; pulse_n[i] = 0; aw_n[i] = 0; w_n[i] = 0;
            aw_c[i] = -1; w_c[i] = -1; ar_c[i] = -1;
        end
        busy = 0; req_active = 0; rand_mode = 0; pulse_now = 0; e_err = 0; e_rdata = '0;
        drop_left = 0; gen_cnt = 0; done_cnt = 0; next_id = 0; cur_id = 0; last_done = 0;

        repeat (3) @(posedge clk_i);
        #2;
        chk("rst_gnt_o", gnt_o, 1'b0);
        chk("rst_aw_valid_o", aw_valid_o, 1'b0);
        chk("rst_w_valid_o", w_valid_o, 1'b0);
        chk("rst_ar_valid_o", ar_valid_o, 1'b0);
        chk("rst_b_ready_o", b_ready_o, 1'b0);
        chk("rst_r_ready_o", r_ready_o, 1'b0);
        chk("rst_r_valid_o", r_valid_o, 1'b0);
        chk("rst_err_o", err_o, 1'b0);
        chk("rst_r_rdata_o", r_rdata_o, 32'h0);
        chk("rst_aw_addr_o", aw_addr_o, 32'h0);
        chk("rst_w_strb_o", w_strb_o, 4'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        q.push_back(mk(0, 32'h1000, 0, 4'hF, 32'hDEADBEEF, 2'b00, 0, 0, 0, 0, 0));
        q.push_back(mk(1, 32'h2004, 32'h12345678, 4'b1100, 0, 2'b00, 0, 3, 0, 0, 0));
        q.push_back(mk(1, 32'h3000, 32'hA5A5A5A5, 4'hF, 0, 2'b10, 2, 0, 0, 0, 0));
        q.push_back(mk(0, 32'h4000, 0, 4'hF, 32'hFFFFFFFF, 2'b11, 0, 0, 0, 0, 0));
        q.push_back(mk(0, 32'h5000, 0, 4'hF, 32'h0BADF00D, 2'b00, 0, 0, 0, 1, 1));
        q.push_back(mk(0, 32'h6000, 0, 4'hF, 32'h11111111, 2'b00, 0, 0, 0, 0, 0));
        q.push_back(mk(0, 32'h7000, 0, 4'hF, 32'h22222222, 2'b00, 0, 0, 0, 0, 0));

        while (done_cnt < TOTAL && cyc < BUDGET) begin
            if (done_cnt >= NUM_DIR && q.size() == 0 && !busy) rand_mode = 1'b1;
            cycle_step();
        end
        if (cyc >= BUDGET) chk("timeout_all_done", done_cnt, TOTAL);
        repeat (3) cycle_step();

        chk("t0_ar_addr", ar_addr_log[0], 32'h1000);
        chk("t0_latency", pulse_c[0] - grant_c[0], 3);
        chk("t0_rdata", pulse_rd[0], 32'hDEADBEEF);
        chk("t0_err", pulse_err[0], 1'b0);
        chk("t1_w_after_aw", w_c[1] - aw_c[1], 3);
        chk("t1_w_strb", w_strb_log[1], 4'b1100);
        chk("t1_pulses", pulse_n[1], 1);
        chk("t1_err", pulse_err[1], 1'b0);
        chk("t2_w_before_aw", w_c[2] < aw_c[2], 1'b1);
        chk("t2_aw_hs", aw_n[2], 1);
        chk("t2_w_hs", w_n[2], 1);
        chk("t2_err", pulse_err[2], 1'b1);
        chk("t3_err", pulse_err[3], 1'b1);
        chk("t3_rdata", pulse_rd[3], 32'h0);
        chk("t4_no_pulse", pulse_n[4], 0);
        chk("t4_ar_done", ar_c[4] >= 0, 1'b1);
        chk("t6_grant_on_pulse5", grant_c[6], pulse_c[5]);
        chk("t6_ar_next_cycle", ar_c[6] - grant_c[6], 1);

        // Asynchronous reset in the middle of a read address phase.
        @(posedge clk_i);
        #1;
        dmactive_i = 1'b1; req_i = 1'b1; we_i = 1'b0; add_i = 32'h8000;
        aw_ready_i = 0; w_ready_i = 0; ar_ready_i = 0; b_valid_i = 0; r_valid_i = 0;
        @(posedge clk_i);
        #1;
        req_i = 1'b0;
        #1;
        chk("pre_rst_ar_valid", ar_valid_o, 1'b1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("async_rst_ar_valid", ar_valid_o, 1'b0);
        chk("async_rst_r_valid", r_valid_o, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dm_sba_axil_bridge.md
Name: dm_sba_axil_bridge

Overview:
- Sits directly downstream of the debug-module system bus access unit.
- Converts its single-outstanding req/gnt/r_valid master port into an AXI4-Lite master.
- Lets the debugger reach system memory over the SoC AXI-Lite fabric.
- Returns read data, write completion and a bus-error flag, which upstream maps to sberror=2.

Parameters:
- BusWidth, 32, address and data width (legal: 32 or 64); strobe width BusWidth/8.
- AxProt, 3'b010, constant driven on aw_prot_o/ar_prot_o (unprivileged, non-secure, data).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- dmactive_i  in  1  debug module active; low blocks new grants
- req_i  in  1  upstream request, held until gnt_o
- add_i  in  BusWidth  request address
- we_i  in  1  1=write, 0=read
- wdata_i  in  BusWidth  write data
- be_i  in  BusWidth/8  byte enables
- gnt_o  out  1  request accepted
- r_valid_o  out  1  one-cycle completion pulse (reads and writes)
- r_rdata_o  out  BusWidth  read data, valid with r_valid_o
- err_o  out  1  bus error, valid with r_valid_o
- aw_valid_o, aw_ready_i, aw_addr_o[BusWidth], aw_prot_o[3]  AXI write address
- w_valid_o, w_ready_i, w_data_o[BusWidth], w_strb_o[BusWidth/8]  AXI write data
- b_valid_i, b_ready_o, b_resp_i[2]  AXI write response
- ar_valid_o, ar_ready_i, ar_addr_o[BusWidth], ar_prot_o[3]  AXI read address
- r_valid_i, r_ready_o, r_data_i[BusWidth], r_resp_i[2]  AXI read response

Behaviour:
- Reset values: all AXI valids/readies 0, r_valid_o 0, err_o 0, r_rdata_o 0, captured add/wdata/be 0, aw_done/w_done 0, state Idle.
- FSM states: Idle, Write, Read, WaitB, WaitR. One transaction outstanding at most.
- Idle:
  - gnt_o = req_i & dmactive_i (combinational; 0 in all other states).
  - On gnt_o, register add_i/we_i/wdata_i/be_i; go to Write if we_i, else Read.
- Write:
  - aw_valid_o = ~aw_done, w_valid_o = ~w_done; both are raised together in the cycle after grant.
  - aw_done / w_done set on their respective handshakes; AW and W may complete in either order or the same cycle.
  - Enter WaitB in the cycle both are done (counting a same-cycle handshake); clear both flags on exit.
- Read: ar_valid_o=1; on ar_ready_i go to WaitR.
- WaitB:
  - b_ready_o=1.
  - On b_valid_i: next cycle r_valid_o=1, err_o=b_resp_i[1], r_rdata_o unchanged.
  - Return to Idle.
- WaitR:
  - r_ready_o=1.
  - On r_valid_i: next cycle r_valid_o=1, err_o=r_resp_i[1], r_rdata_o = error ? 0 : r_data_i.
  - Return to Idle.
- Response outputs are registered; r_valid_o is high exactly one cycle.
  - A new gnt_o may occur in that same cycle (state already Idle).
- AXI rules:
  - Valid, once raised, is held until its ready.
  - aw/w/ar payload comes from registers and is stable while valid.
  - aw_addr_o/ar_addr_o = captured address unmodified; w_strb_o = captured be.
  - prot = AxProt.
- Latency (ready/valid immediate):
  - Grant at cycle N; AW/W or AR valid at N+1.
  - b/r handshake at N+2; r_valid_o at N+3.
- dmactive_i low:
  - No new grants.
  - An in-flight AXI transaction always completes protocol-correctly.
  - Its r_valid_o pulse is suppressed if dmactive_i is low in the handshake cycle.
- Responses arriving outside WaitB/WaitR are ignored (readies are 0).
- Asynchronous reset mid-transaction returns to Idle immediately; fabric-side reset is the system's responsibility.

Decomposition:
- dm_pkg holds:
  - AXI response constants AXI_RESP_OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
  - The default prot constant.
- State enum is local to the module.
- No sub-module; the two-flag AW/W join is inline.

Test Plan:
- Read 0x1000, ar_ready/r_valid immediate, r_data=0xDEADBEEF, OKAY -> ar_addr=0x1000; r_valid_o at grant+3; r_rdata_o=0xDEADBEEF; err_o=0.
- Write 0x2004, data 0x12345678, be=4'b1100; w_ready 3 cycles after aw_ready -> AW/W held stable until their handshakes; w_strb=4'b1100; single r_valid_o after b_valid; err_o=0.
- Write with W accepted before AW and b_resp=SLVERR -> exactly one AW and one W handshake; r_valid_o with err_o=1.
- Read returning DECERR, r_data=0xFFFFFFFF -> r_valid_o=1, err_o=1, r_rdata_o=0.
- dmactive_i dropped while in WaitR, then r_valid_i -> r_ready_o handshake occurs; no r_valid_o; gnt_o stays 0 while req_i=1.
- Back-to-back reads with req_i held -> second gnt_o coincides with the first r_valid_o cycle; the second ar_valid_o follows one cycle later.
